// File: rtl/axi_fir_coef_regs.sv
// AXI4-Lite register block for a FIR filter: double-buffered coefficient bank
// (shadow written over the bus, copied to the active bank on a load command).
module axi_fir_coef_regs #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int N_TAPS       = 32,
    parameter int COEF_WIDTH   = 14
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [C_ADDR_WIDTH-1:0]      AWADDR,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [31:0]                  WDATA,
    input  logic [3:0]                   WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [C_ADDR_WIDTH-1:0]      ARADDR,
    input  logic [2:0]                   ARPROT,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [31:0]                  RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [N_TAPS*COEF_WIDTH-1:0] coef_o,
    output logic                         fir_en_o,
    output logic                         load_done_o
);

    localparam int          WA          = C_ADDR_WIDTH - 2;
    localparam int          SHADOW_BASE = 32;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ID_VALUE    = 32'h46495232;

    typedef enum logic [1:0] {W_IDLE, W_GOTADDR, W_GOTDATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic [WA-1:0]         awaddr_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            wstrb_reg;
    logic [1:0]            bresp_reg;
    logic [1:0]            rresp_reg;
    logic [31:0]           rdata_reg;
    logic                  ctrl_en_reg;
    logic                  load_req_reg;
    logic                  load_done_reg;
    logic                  dirty_reg;
    logic [COEF_WIDTH-1:0] shadow_reg [N_TAPS];
    logic [COEF_WIDTH-1:0] coef_reg   [N_TAPS];
    logic [31:0]           shadow_ext [N_TAPS];

    logic                  aw_ready, w_ready, aw_hs, w_hs, ar_hs, wr_fire;
    logic [WA-1:0]         eff_word;
    logic [31:0]           eff_wdata;
    logic [3:0]            eff_strb;
    logic [31:0]           wr_word_ext, rd_word_ext;
    logic [COEF_WIDTH-1:0] coef_mask;
    logic [N_TAPS-1:0]     wr_tap_sel;
    logic                  wr_is_ctrl, wr_hit;
    logic [31:0]           rd_data_next;
    logic [1:0]            rd_resp_next;
    logic                  unused_bits;

    // Address/data come from the latch when that half arrived earlier.
    assign eff_word    = (w_state_reg == W_GOTADDR) ? awaddr_reg : AWADDR[C_ADDR_WIDTH-1:2];
    assign eff_wdata   = (w_state_reg == W_GOTDATA) ? wdata_reg  : WDATA;
    assign eff_strb    = (w_state_reg == W_GOTDATA) ? wstrb_reg  : WSTRB;
    assign wr_word_ext = 32'(eff_word);
    assign rd_word_ext = 32'(ARADDR[C_ADDR_WIDTH-1:2]);

    assign aw_hs = AWVALID && aw_ready;
    assign w_hs  = WVALID && w_ready;
    assign ar_hs = ARVALID && (r_state_reg == R_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < COEF_WIDTH; gi++) begin : g_mask
            assign coef_mask[gi] = eff_strb[gi / 8];
        end
        for (gi = 0; gi < N_TAPS; gi++) begin : g_tap
            assign shadow_ext[gi] = {{(32-COEF_WIDTH){shadow_reg[gi][COEF_WIDTH-1]}}, shadow_reg[gi]};
            assign coef_o[gi*COEF_WIDTH +: COEF_WIDTH] = coef_reg[gi];
            assign wr_tap_sel[gi] = (wr_word_ext == 32'(SHADOW_BASE + gi));
        end
    endgenerate

    assign wr_is_ctrl = (wr_word_ext == 32'd0);
    assign wr_hit     = wr_is_ctrl || (wr_word_ext == 32'd1) || (wr_word_ext == 32'd2) || (|wr_tap_sel);

    always_comb begin
        w_state_next = w_state_reg;
        aw_ready     = 1'b0;
        w_ready      = 1'b0;
        wr_fire      = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                aw_ready = 1'b1;
                w_ready  = 1'b1;
                if (AWVALID && WVALID) begin
                    w_state_next = W_RESP;
                    wr_fire      = 1'b1;
                end else if (AWVALID) begin
                    w_state_next = W_GOTADDR;
                end else if (WVALID) begin
                    w_state_next = W_GOTDATA;
                end
            end
            W_GOTADDR: begin
                w_ready = 1'b1;
                if (WVALID) begin
                    w_state_next = W_RESP;
                    wr_fire      = 1'b1;
                end
            end
            W_GOTDATA: begin
                aw_ready = 1'b1;
                if (AWVALID) begin
                    w_state_next = W_RESP;
                    wr_fire      = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ARVALID) r_state_next = R_DATA;
            R_DATA:  if (RREADY)  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Load bit is write-only: CTRL reads back only the enable.
    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_OKAY;
        if (rd_word_ext == 32'd0) begin
            rd_data_next = {31'b0, ctrl_en_reg};
        end else if (rd_word_ext == 32'd1) begin
            rd_data_next = {30'b0, dirty_reg, ctrl_en_reg};
        end else if (rd_word_ext == 32'd2) begin
            rd_data_next = ID_VALUE;
        end else begin
            rd_resp_next = RESP_SLVERR;
            for (int k = 0; k < N_TAPS; k++) begin
                if (rd_word_ext == 32'(SHADOW_BASE + k)) begin
                    rd_data_next = shadow_ext[k];
                    rd_resp_next = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_reg   <= W_IDLE;
            r_state_reg   <= R_IDLE;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            bresp_reg     <= RESP_OKAY;
            rresp_reg     <= RESP_OKAY;
            rdata_reg     <= '0;
            ctrl_en_reg   <= 1'b0;
            load_req_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            dirty_reg     <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_reg[k] <= '0;
                coef_reg[k]   <= '0;
            end
        end else begin
            w_state_reg   <= w_state_next;
            r_state_reg   <= r_state_next;
            load_req_reg  <= 1'b0;
            load_done_reg <= 1'b0;

            if (aw_hs) awaddr_reg <= AWADDR[C_ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_reg <= WDATA;
                wstrb_reg <= WSTRB;
            end

            // Bank swap one edge after the CTRL write; a shadow write landing on
            // the same edge is not copied and keeps the bank dirty.
            if (load_req_reg) begin
                for (int k = 0; k < N_TAPS; k++) coef_reg[k] <= shadow_reg[k];
                load_done_reg <= 1'b1;
                dirty_reg     <= 1'b0;
            end

            if (wr_fire) begin
                bresp_reg <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                if (wr_is_ctrl && eff_strb[0]) begin
                    ctrl_en_reg  <= eff_wdata[0];
                    load_req_reg <= eff_wdata[1];
                end
                for (int k = 0; k < N_TAPS; k++) begin
                    if (wr_tap_sel[k]) begin
                        shadow_reg[k] <= (shadow_reg[k] & ~coef_mask) |
                                         (eff_wdata[COEF_WIDTH-1:0] & coef_mask);
                        dirty_reg     <= 1'b1;
                    end
                end
            end

            if (ar_hs) begin
                rdata_reg <= rd_data_next;
                rresp_reg <= rd_resp_next;
            end
        end
    end

    assign AWREADY     = aw_ready;
    assign WREADY      = w_ready;
    assign BVALID      = (w_state_reg == W_RESP);
    assign BRESP       = bresp_reg;
    assign ARREADY     = (r_state_reg == R_IDLE);
    assign RVALID      = (r_state_reg == R_DATA);
    assign RDATA       = rdata_reg;
    assign RRESP       = rresp_reg;
    assign fir_en_o    = ctrl_en_reg;
    assign load_done_o = load_done_reg;

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0], eff_wdata, eff_strb};

endmodule

// File: doc/axi_fir_coef_regs.md
AXI_FIR_COEF_REGS -- requirements
Module: axi_fir_coef_regs

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 8, AXI4-Lite byte-address width.
REQ-002 SHALL have parameter N_TAPS, default 32, number of FIR coefficients.
REQ-003 SHALL have parameter COEF_WIDTH, default 14, signed coefficient width.
REQ-004 SHALL have ports ACLK  in  1  clock; ARESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have AXI4-Lite write-address ports: AWADDR in C_ADDR_WIDTH; AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1.
REQ-006 SHALL have AXI4-Lite write-data ports: WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1.
REQ-007 SHALL have AXI4-Lite write-response ports: BRESP out 2; BVALID out 1; BREADY in 1.
REQ-008 SHALL have AXI4-Lite read-address ports: ARADDR in C_ADDR_WIDTH; ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1.
REQ-009 SHALL have AXI4-Lite read-data ports: RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1.
REQ-010 SHALL have filter-side outputs: coef_o out N_TAPS*COEF_WIDTH, active bank, tap k at bits [k*COEF_WIDTH +: COEF_WIDTH]; fir_en_o out 1, filter enable; load_done_o out 1, one-cycle pulse on bank swap.

Function
REQ-011 SHALL decode word address addr[C_ADDR_WIDTH-1:2]; low two bits ignored.
REQ-012 SHALL implement the following map: 0x00 CTRL (RW: bit0 enable, bit1 load, self-clearing); 0x04 STATUS (RO: bit0 fir_en_o, bit1 shadow dirty); 0x08 ID (RO, constant 0x46495232); 0x80+4k SHADOW[k], RW, k=0..N_TAPS-1.
REQ-013 SHALL respond SLVERR (2'b10) to any other address; writes there have no effect and reads return 0. Mapped accesses SHALL respond OKAY (2'b00). Writes to RO registers SHALL respond OKAY and be ignored.
REQ-014 SHALL implement the write FSM with states W_IDLE, W_GOTADDR, W_GOTDATA, W_RESP.
REQ-015 W_IDLE asserts AWREADY and WREADY. On AW and W handshakes in the same cycle, SHALL go to W_RESP. On AW only, SHALL latch the address and go to W_GOTADDR. On W only, SHALL latch data and strobe and go to W_GOTDATA.
REQ-016 W_GOTADDR asserts only WREADY; W_GOTDATA asserts only AWREADY. On completing the handshake, either state SHALL go to W_RESP.
REQ-017 The register update SHALL occur in the cycle the FSM enters W_RESP. BVALID SHALL be high in W_RESP and held with stable BRESP until BREADY; the FSM then returns to W_IDLE. Latency is 1 cycle from the final handshake to BVALID.
REQ-018 Writes SHALL honor WSTRB per byte. SHADOW[k] stores WDATA[COEF_WIDTH-1:0] under the strobes of the bytes covering those bits.
REQ-019 Reads of SHADOW[k] SHALL return the value sign-extended to 32 bits.
REQ-020 SHALL implement the read FSM with states R_IDLE and R_DATA. ARREADY is high only in R_IDLE. On the AR handshake, RDATA/RRESP SHALL be registered and the FSM goes to R_DATA, with RVALID high the next cycle. RDATA/RRESP SHALL be held stable until RREADY, then the FSM returns to R_IDLE.
REQ-021 Read and write channels SHALL be independent. A read of a register written in the same cycle SHALL return the pre-write value.
REQ-022 Writing CTRL with bit1=1 SHALL copy all SHADOW into the active bank (coef_o) on the next clock edge and pulse load_done_o for one cycle. Bit1 SHALL read back as 0.
REQ-023 Any SHADOW write SHALL set the dirty bit. A load SHALL clear it. If a SHADOW write and a load take effect in the same cycle, the load SHALL copy the pre-write shadow and dirty SHALL remain 1.
REQ-024 fir_en_o SHALL equal CTRL bit0 directly from its register.

Reset
REQ-025 ARESET high SHALL immediately set: write FSM to W_IDLE, read FSM to R_IDLE, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, CTRL=0, dirty=0, all SHADOW=0, coef_o=0, load_done_o=0.
REQ-026 Reset asserted mid-transaction SHALL abandon that transaction with no response issued. AWREADY, WREADY and ARREADY SHALL be 1 in the first cycle after release.

Verification
REQ-027 Write 0x1FFF to 0x80, then read 0x80 -> BRESP=OKAY; RDATA=0x00001FFF; coef_o tap0 still 0.
REQ-028 Write 0x2000 to 0xFC, then write 0x2 to CTRL -> load_done_o pulses once; tap31 = 14'h2000; reading 0xFC returns 0xFFFFE000; STATUS bit1 = 0.
REQ-029 AW at cycle 0, W at cycle 3, BREADY held low 4 cycles -> BVALID first high at cycle 4 and stays high with BRESP stable until BREADY.
REQ-030 Write 0xABCD to 0x84 with WSTRB=4'b0001 after tap1 = 0x1234 -> SHADOW[1] = 0x12CD.
REQ-031 Read 0x40 and write 0x0C -> both respond SLVERR; the read returns 0; no register changes.
REQ-032 Assert ARESET while BVALID and RVALID are both high -> both drop asynchronously; all outputs read 0; a normal write after release completes with OKAY.
